beta_fetch_stage: RTL and testbench
===================================

# beta_fetch_stage

Instruction fetch stage of the beta core. It sits directly upstream of the pipeline control unit and the IF-DEC pipe. It issues one word-aligned instruction read per fetch enable over a req/gnt/rvalid memory port and holds the PC. It reports busy to the control unit, presents the fetched word with its PC to the IF-DEC pipe, and takes branch/jump/trap redirects from the exe stage.

## Interface
- DataWidth, 32, instruction/data word width
- AddrWidth, 32, address width
- BootAddr, 32'h0000_0000, PC value loaded at reset (bits [1:0] must be 0)
- clk_i  in  1  core clock
- rstn_i  in  1  reset, asynchronous, active-low
- ifs_fetch_en_i  in  1  start one fetch; driven by the control unit
- ifs_busy_o  out  1  high while a fetch is in flight (state != IDLE)
- ifs_redirect_i  in  1  control/trap hazard: discard in-flight work and load a new PC
- ifs_redirect_addr_i  in  AddrWidth  target PC; bits [1:0] forced to 0 on load
- mem_req_o  out  1  read request
- mem_addr_o  out  AddrWidth  request address, equal to the PC
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; always arrives at least 1 cycle after the grant
- mem_rdata_i  in  DataWidth  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- ifs_instr_o  out  DataWidth  fetched instruction, held until the next delivery
- ifs_pc_o  out  AddrWidth  PC of ifs_instr_o
- ifs_valid_o  out  1  one-cycle pulse: new instruction in ifs_instr_o/ifs_pc_o
- ifs_fault_o  out  1  instruction access fault, qualified by ifs_valid_o

## Operation
- FSM states:
  - IDLE: waits for a fetch.
  - REQ: mem_req_o=1, mem_addr_o=pc.
  - WAIT: one transaction outstanding.
- IDLE→REQ on ifs_fetch_en_i. REQ→WAIT on mem_gnt_i. WAIT→IDLE on mem_rvalid_i.
- Only one outstanding transaction. mem_req_o is combinational from state==REQ.
- On an accepted (non-discarded) response:
  - Register ifs_instr_o=mem_rdata_i and ifs_pc_o=pc.
  - Pulse ifs_valid_o.
  - pc <= pc+4, modulo 2^AddrWidth; 0xFFFF_FFFC wraps to 0.
- Redirect has priority over every other event. It always does pc <= {ifs_redirect_addr_i[AddrWidth-1:2],2'b00}.
  - In IDLE: state stays IDLE; fetch_en in the same cycle goes to REQ using the new PC on the next cycle.
  - In REQ without gnt: stays in REQ; the address switches to the new PC next cycle.
  - In REQ with gnt in the same cycle: go to WAIT and set the discard flag.
  - In WAIT: set the discard flag.
- Discarded response: the data is dropped, no ifs_valid_o, the discard flag clears, state→IDLE.
- Redirect in the same cycle as an accepted rvalid: that response is discarded and the PC takes the redirect target.
- ifs_fetch_en_i outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, pc=BootAddr, discard=0, ifs_instr_o=0, ifs_pc_o=0, ifs_valid_o=0, ifs_fault_o=0, mem_req_o=0, ifs_busy_o=0.
- Minimum latency is 4 cycles from fetch_en to instruction visible:
  - cycle 0: fetch_en.
  - cycle 1: req with gnt.
  - cycle 2: rvalid.
  - cycle 3: ifs_valid_o high.
- Each extra cycle of gnt or rvalid wait adds one cycle.
- ifs_busy_o rises the cycle after fetch_en and falls the cycle ifs_valid_o rises.
- Back-to-back fetch_en: the next REQ is entered at the earliest in the cycle after ifs_valid_o.
- Reset mid-transaction: return to IDLE immediately. The memory port must not deliver stale rvalid after reset; this is the memory side's responsibility.

## Configuration
- BETA_IFS_ACCESS_FAULT_EN defined:
  - mem_err_i with an accepted rvalid sets ifs_fault_o=1 alongside ifs_valid_o.
  - ifs_instr_o=32'h0000_0013 (NOP); pc is not incremented.
  - ifs_fault_o clears on the next delivery.
- Not defined: mem_err_i is ignored, ifs_fault_o is tied to 0, and rdata is delivered as-is.

## Structure
- beta_pkg gains:
  - the ifs_state_t enum (IDLE, REQ, WAIT);
  - the constant BETA_NOP_INSTR = 32'h0000_0013;
  - the constant BETA_INSTR_BYTES = 4.
- No sub-module; single FSM plus PC/output registers.

## Test plan
- Reset with BootAddr=0x100 → addr 0x100 requested; rvalid rdata=0x00500093 → ifs_valid_o at cycle 3, instr 0x00500093, pc 0x100; next fetch addr 0x104.
- gnt delayed 3 cycles, rvalid delayed 2 → ifs_valid_o at cycle 8, ifs_busy_o high cycles 1–7.
- Redirect to 0x2002 during WAIT, then rvalid → no ifs_valid_o; next fetch_en requests 0x2000.
- Redirect coincident with gnt of 0x104 → that response is dropped; next fetch requests the target.
- pc=0xFFFF_FFFC fetch → ifs_pc_o=0xFFFF_FFFC, next request addr 0x0.
- With BETA_IFS_ACCESS_FAULT_EN, mem_err_i=1 on rvalid → ifs_fault_o=1, instr=0x00000013, next addr unchanged; without the macro → ifs_fault_o=0 and rdata passed through.

Source files
------------

// File: rtl/beta_pkg.sv
// -----------------------------------------------------------------------------
// beta_pkg
// Shared types and constants for the beta core.
//   ifs_state_t      : fetch stage FSM states (IDLE, REQ, WAIT)
//   BETA_NOP_INSTR   : canonical NOP (addi x0, x0, 0) substituted on faults
//   BETA_INSTR_BYTES : instruction size in bytes, the PC increment
// -----------------------------------------------------------------------------
package beta_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifs_state_t;

    localparam logic [31:0] BETA_NOP_INSTR   = 32'h0000_0013;
    localparam int          BETA_INSTR_BYTES = 4;

endpackage : beta_pkg

// File: rtl/beta_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// beta_fetch_stage_if
// Instruction memory read port (req/gnt/rvalid) of the fetch stage.
//   mem_req_o    : read request               (master -> slave)
//   mem_addr_o   : word-aligned read address  (master -> slave)
//   mem_gnt_i    : request accepted           (slave -> master)
//   mem_rvalid_i : read data valid            (slave -> master)
//   mem_rdata_i  : read data                  (slave -> master)
//   mem_err_i    : bus error, with rvalid     (slave -> master)
// Modports: master = fetch stage, slave = memory.
// -----------------------------------------------------------------------------
interface beta_fetch_stage_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);

    logic                 mem_req_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic                 mem_gnt_i;
    logic                 mem_rvalid_i;
    logic [DataWidth-1:0] mem_rdata_i;
    logic                 mem_err_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        input  mem_err_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i,
        output mem_err_i
    );

endinterface : beta_fetch_stage_if

// File: rtl/beta_fetch_stage.sv
// -----------------------------------------------------------------------------
// beta_fetch_stage
// Instruction fetch stage of the beta core. Holds the PC, issues one read per
// fetch enable (single outstanding transaction), delivers the fetched word and
// its PC to the IF-DEC pipe, and accepts redirects from the exe stage.
//
// Ports:
//   clk_i, rstn_i        : clock, asynchronous active-low reset
//   ifs_fetch_en_i       : start one fetch (honoured only in IDLE)
//   ifs_busy_o           : a fetch is in flight
//   ifs_redirect_i       : discard in-flight work, load ifs_redirect_addr_i
//   ifs_redirect_addr_i  : redirect target (low two bits forced to zero)
//   mem                  : instruction memory port (beta_fetch_stage_if.master)
//   ifs_instr_o/ifs_pc_o : last delivered instruction and its PC
//   ifs_valid_o          : one-cycle pulse per delivered instruction
//   ifs_fault_o          : instruction access fault, qualified by ifs_valid_o
//
// Configuration:
//   BETA_IFS_ACCESS_FAULT_EN : when defined, a bus error on the response
//   delivers a NOP with ifs_fault_o set and leaves the PC unchanged. When not
//   defined, mem_err_i is ignored and ifs_fault_o stays 0.
// -----------------------------------------------------------------------------
module beta_fetch_stage
    import beta_pkg::*;
#(
    parameter int                   DataWidth = 32,
    parameter int                   AddrWidth = 32,
    parameter logic [AddrWidth-1:0] BootAddr  = '0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  ifs_fetch_en_i,
    output logic                  ifs_busy_o,
    input  logic                  ifs_redirect_i,
    input  logic [AddrWidth-1:0]  ifs_redirect_addr_i,
    beta_fetch_stage_if.master    mem,
    output logic [DataWidth-1:0]  ifs_instr_o,
    output logic [AddrWidth-1:0]  ifs_pc_o,
    output logic                  ifs_valid_o,
    output logic                  ifs_fault_o
);

    ifs_state_t           state_q, state_d;
    logic [AddrWidth-1:0] pc_q, pc_d;
    logic                 discard_q, discard_d;
    logic [DataWidth-1:0] instr_q, instr_d;
    logic [AddrWidth-1:0] ifs_pc_q, ifs_pc_d;
    logic                 valid_q, valid_d;
    logic                 fault_q, fault_d;

    logic [AddrWidth-1:0] redirect_pc;
    assign redirect_pc = {ifs_redirect_addr_i[AddrWidth-1:2], 2'b00};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        instr_d   = instr_q;
        ifs_pc_d  = ifs_pc_q;
        valid_d   = 1'b0;
        fault_d   = fault_q;

        case (state_q)
            IDLE: begin
                if (ifs_fetch_en_i) state_d = REQ;
            end
            REQ: begin
                if (mem.mem_gnt_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem.mem_rvalid_i) begin
                    state_d = IDLE;
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        valid_d  = 1'b1;
                        instr_d  = mem.mem_rdata_i;
                        ifs_pc_d = pc_q;
                        pc_d     = pc_q + AddrWidth'(BETA_INSTR_BYTES);
                        fault_d  = 1'b0;
`ifdef BETA_IFS_ACCESS_FAULT_EN
                        // Faulting fetch: hand a NOP downstream and keep the
                        // PC so the trap handler sees the faulting address.
                        if (mem.mem_err_i) begin
                            instr_d = DataWidth'(BETA_NOP_INSTR);
                            fault_d = 1'b1;
                            pc_d    = pc_q;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything computed above.
        if (ifs_redirect_i) begin
            pc_d = redirect_pc;
            if (state_q == REQ && mem.mem_gnt_i) begin
                discard_d = 1'b1;
            end else if (state_q == WAIT) begin
                if (mem.mem_rvalid_i) begin
                    // Response arrives with the redirect: drop it in place.
                    valid_d   = 1'b0;
                    instr_d   = instr_q;
                    ifs_pc_d  = ifs_pc_q;
                    fault_d   = fault_q;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            pc_q      <= BootAddr;
            discard_q <= 1'b0;
            instr_q   <= '0;
            ifs_pc_q  <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            ifs_pc_q  <= ifs_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign mem.mem_req_o  = (state_q == REQ);
    assign mem.mem_addr_o = pc_q;
    assign ifs_busy_o     = (state_q != IDLE);
    assign ifs_instr_o    = instr_q;
    assign ifs_pc_o       = ifs_pc_q;
    assign ifs_valid_o    = valid_q;
    assign ifs_fault_o    = fault_q;

endmodule : beta_fetch_stage

// File: tb/tb_beta_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_beta_fetch_stage
// Directed bench for beta_fetch_stage (BootAddr = 0x100). The stimulus side
// plays the control unit and the memory; every delivery it expects is pushed
// onto a scoreboard queue, and a monitor on the falling clock edge pops and
// compares whenever ifs_valid_o is high. Expectations follow
// BETA_IFS_ACCESS_FAULT_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_beta_fetch_stage;
    import beta_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        ifs_fetch_en_i;
    logic        ifs_busy_o;
    logic        ifs_redirect_i;
    logic [31:0] ifs_redirect_addr_i;
    logic [31:0] ifs_instr_o;
    logic [31:0] ifs_pc_o;
    logic        ifs_valid_o;
    logic        ifs_fault_o;

    beta_fetch_stage_if #(.DataWidth(32), .AddrWidth(32)) mem_if ();

    beta_fetch_stage #(
        .DataWidth (32),
        .AddrWidth (32),
        .BootAddr  (32'h0000_0100)
    ) dut (
        .clk_i               (clk_i),
        .rstn_i              (rstn_i),
        .ifs_fetch_en_i      (ifs_fetch_en_i),
        .ifs_busy_o          (ifs_busy_o),
        .ifs_redirect_i      (ifs_redirect_i),
        .ifs_redirect_addr_i (ifs_redirect_addr_i),
        .mem                 (mem_if.master),
        .ifs_instr_o         (ifs_instr_o),
        .ifs_pc_o            (ifs_pc_o),
        .ifs_valid_o         (ifs_valid_o),
        .ifs_fault_o         (ifs_fault_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_compared = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t make_exp(input logic [31:0] addr, input logic [31:0] data,
                                      input logic err);
        exp_t e;
        e.instr = data;
        e.pc    = addr;
        e.fault = 1'b0;
`ifdef BETA_IFS_ACCESS_FAULT_EN
        if (err) begin
            e.instr = BETA_NOP_INSTR;
            e.fault = 1'b1;
        end
`else
        if (err) e.fault = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard monitor: every ifs_valid_o pulse must match the oldest entry.
    always @(negedge clk_i) begin
        if (rstn_i === 1'b1 && ifs_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(ifs_valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", ifs_instr_o, e.instr);
                check("sb_pc", ifs_pc_o, e.pc);
                check("sb_fault", 32'(ifs_fault_o), 32'(e.fault));
            end
        end
    end

    // One complete fetch, entered at cycle 0 (1 unit after an edge).
    // gd = idle cycles before gnt, rd = idle cycles between gnt and rvalid.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                         input int gd, input int rd);
        exp_q.push_back(make_exp(addr, data, err));
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i = 1'b0;
        ifs_redirect_i = 1'b0;
        check("req_addr", mem_if.mem_addr_o, addr);
        check("req_high", 32'(mem_if.mem_req_o), 32'd1);
        for (int i = 0; i < gd; i++) begin
            check("busy_gnt_wait", 32'(ifs_busy_o), 32'd1);
            cyc();
        end
        mem_if.mem_gnt_i = 1'b1;
        check("busy_at_gnt", 32'(ifs_busy_o), 32'd1);
        cyc();
        mem_if.mem_gnt_i = 1'b0;
        check("req_low_in_wait", 32'(mem_if.mem_req_o), 32'd0);
        for (int i = 0; i < rd; i++) begin
            check("busy_rvalid_wait", 32'(ifs_busy_o), 32'd1);
            cyc();
        end
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = data;
        mem_if.mem_err_i    = err;
        cyc();
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_err_i    = 1'b0;
        check("valid_latency", 32'(ifs_valid_o), 32'd1);
        check("busy_fall", 32'(ifs_busy_o), 32'd0);
        cyc();
        check("valid_one_cycle", 32'(ifs_valid_o), 32'd0);
    endtask

    logic [31:0] next_addr;

    initial begin
        rstn_i              = 1'b0;
        ifs_fetch_en_i      = 1'b0;
        ifs_redirect_i      = 1'b0;
        ifs_redirect_addr_i = '0;
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;
        mem_if.mem_err_i    = 1'b0;

        // Reset values
        cyc();
        check("rst_busy", 32'(ifs_busy_o), 32'd0);
        check("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        check("rst_valid", 32'(ifs_valid_o), 32'd0);
        check("rst_fault", 32'(ifs_fault_o), 32'd0);
        check("rst_instr", ifs_instr_o, 32'd0);
        check("rst_pc_out", ifs_pc_o, 32'd0);
        check("rst_addr", mem_if.mem_addr_o, 32'h100);
        rstn_i = 1'b1;
        cyc();

        // Minimum latency fetch from BootAddr, then delayed gnt/rvalid at 0x104
        fetch(32'h100, 32'h0050_0093, 1'b0, 0, 0);
        fetch(32'h104, 32'h1111_1111, 1'b0, 3, 2);
        check("addr_after_two", mem_if.mem_addr_o, 32'h108);

        // Redirect during WAIT (fetch_en there is ignored), response dropped
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i   = 1'b0;
        mem_if.mem_gnt_i = 1'b1;
        cyc();
        mem_if.mem_gnt_i    = 1'b0;
        ifs_redirect_i      = 1'b1;
        ifs_redirect_addr_i = 32'h2002;
        ifs_fetch_en_i      = 1'b1;
        cyc();
        ifs_redirect_i      = 1'b0;
        ifs_fetch_en_i      = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hDEAD_BEEF;
        cyc();
        mem_if.mem_rvalid_i = 1'b0;
        check("wait_redir_no_valid", 32'(ifs_valid_o), 32'd0);
        check("wait_redir_idle", 32'(ifs_busy_o), 32'd0);
        check("wait_redir_instr_held", ifs_instr_o, 32'h1111_1111);
        fetch(32'h2000, 32'h2222_2222, 1'b0, 0, 1);

        // Redirect coincident with gnt of 0x2004
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i      = 1'b0;
        check("gnt_redir_req_addr", mem_if.mem_addr_o, 32'h2004);
        mem_if.mem_gnt_i    = 1'b1;
        ifs_redirect_i      = 1'b1;
        ifs_redirect_addr_i = 32'h3000;
        cyc();
        mem_if.mem_gnt_i    = 1'b0;
        ifs_redirect_i      = 1'b0;
        check("gnt_redir_in_wait", 32'(ifs_busy_o), 32'd1);
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'hBAD0_BAD0;
        cyc();
        mem_if.mem_rvalid_i = 1'b0;
        check("gnt_redir_no_valid", 32'(ifs_valid_o), 32'd0);
        fetch(32'h3000, 32'h3333_3333, 1'b0, 1, 0);

        // Redirect in REQ without gnt: address switches next cycle
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i      = 1'b0;
        ifs_redirect_i      = 1'b1;
        ifs_redirect_addr_i = 32'h0000_0403;
        cyc();
        ifs_redirect_i = 1'b0;
        check("req_redir_addr", mem_if.mem_addr_o, 32'h400);
        check("req_redir_req", 32'(mem_if.mem_req_o), 32'd1);
        exp_q.push_back(make_exp(32'h400, 32'h4444_4444, 1'b0));
        mem_if.mem_gnt_i = 1'b1;
        cyc();
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'h4444_4444;
        cyc();
        mem_if.mem_rvalid_i = 1'b0;
        check("req_redir_valid", 32'(ifs_valid_o), 32'd1);
        cyc();
        check("req_redir_next_addr", mem_if.mem_addr_o, 32'h404);

        // Redirect with rvalid: response dropped, PC -> 0xFFFF_FFFC
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i   = 1'b0;
        mem_if.mem_gnt_i = 1'b1;
        cyc();
        mem_if.mem_gnt_i    = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = 32'h5555_5555;
        ifs_redirect_i      = 1'b1;
        ifs_redirect_addr_i = 32'hFFFF_FFFE;
        cyc();
        mem_if.mem_rvalid_i = 1'b0;
        ifs_redirect_i      = 1'b0;
        check("rv_redir_no_valid", 32'(ifs_valid_o), 32'd0);
        check("rv_redir_idle", 32'(ifs_busy_o), 32'd0);
        check("rv_redir_addr", mem_if.mem_addr_o, 32'hFFFF_FFFC);

        // PC wrap
        fetch(32'hFFFF_FFFC, 32'h6666_6666, 1'b0, 0, 0);
        fetch(32'h0000_0000, 32'h7777_7777, 1'b0, 0, 0);

        // Redirect and fetch_en together in IDLE: fetch uses the new PC
        ifs_redirect_i      = 1'b1;
        ifs_redirect_addr_i = 32'h500;
        fetch(32'h500, 32'h8888_8888, 1'b0, 0, 0);

        // Bus error on response
        fetch(32'h504, 32'hABCD_EF01, 1'b1, 0, 0);
`ifdef BETA_IFS_ACCESS_FAULT_EN
        next_addr = 32'h504;
`else
        next_addr = 32'h508;
`endif
        check("err_next_addr", mem_if.mem_addr_o, next_addr);
        fetch(next_addr, 32'h9999_9999, 1'b0, 0, 0);

        // Reset mid-transaction returns to IDLE at once
        ifs_fetch_en_i = 1'b1;
        cyc();
        ifs_fetch_en_i = 1'b0;
        check("pre_rst_req", 32'(mem_if.mem_req_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_if.mem_req_o), 32'd0);
        check("mid_rst_busy", 32'(ifs_busy_o), 32'd0);
        check("mid_rst_addr", mem_if.mem_addr_o, 32'h100);
        cyc();
        rstn_i = 1'b1;
        cyc();
        fetch(32'h100, 32'h0050_0093, 1'b0, 0, 0);

        repeat (3) cyc();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_beta_fetch_stage
